// File: rtl/pe_dot_sequencer_pkg.sv
// pe_seq_pkg: shared definitions for the PE dot-product sequencer.
//   - Default width constants used as parameter defaults by the interface,
//     the top and the address generator.
//   - seq_state_e: sequencer FSM state encoding.
package pe_seq_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 10;
    localparam int LEN_WIDTH  = 8;
    localparam int ACC_WIDTH  = 2 * DATA_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ISSUE,
        ST_DRAIN,
        ST_RESP
    } seq_state_e;

endpackage

// File: rtl/pe_dot_sequencer_if.sv
// pe_dot_sequencer_if: bundles the sequencer's command, operand-RAM, PE and
// result signals.
//   master : the sequencer (drives cmd_ready, RAM reads, PE framing, result)
//   slave  : the environment (drives commands, RAM data, PE result, res_ready)
interface pe_dot_sequencer_if #(
    parameter int DATA_WIDTH = pe_seq_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = pe_seq_pkg::ADDR_WIDTH,
    parameter int LEN_WIDTH  = pe_seq_pkg::LEN_WIDTH,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH
);
    import pe_seq_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_a_base;
    logic [ADDR_WIDTH-1:0] cmd_b_base;
    logic [ADDR_WIDTH-1:0] cmd_b_stride;
    logic [LEN_WIDTH-1:0]  cmd_len;

    logic                  mem_a_en;
    logic [ADDR_WIDTH-1:0] mem_a_addr;
    logic [DATA_WIDTH-1:0] mem_a_rdata;
    logic                  mem_b_en;
    logic [ADDR_WIDTH-1:0] mem_b_addr;
    logic [DATA_WIDTH-1:0] mem_b_rdata;

    logic                  pe_start;
    logic                  pe_valid;
    logic                  pe_last;
    logic [DATA_WIDTH-1:0] pe_a;
    logic [DATA_WIDTH-1:0] pe_b;
    logic [ACC_WIDTH-1:0]  pe_c;
    logic                  pe_out_valid;

    logic                  res_valid;
    logic                  res_ready;
    logic [ACC_WIDTH-1:0]  res_data;

    modport master (
        input  cmd_valid, cmd_a_base, cmd_b_base, cmd_b_stride, cmd_len,
        output cmd_ready,
        output mem_a_en, mem_a_addr, mem_b_en, mem_b_addr,
        input  mem_a_rdata, mem_b_rdata,
        output pe_start, pe_valid, pe_last, pe_a, pe_b,
        input  pe_c, pe_out_valid,
        output res_valid, res_data,
        input  res_ready
    );

    modport slave (
        output cmd_valid, cmd_a_base, cmd_b_base, cmd_b_stride, cmd_len,
        input  cmd_ready,
        input  mem_a_en, mem_a_addr, mem_b_en, mem_b_addr,
        output mem_a_rdata, mem_b_rdata,
        input  pe_start, pe_valid, pe_last, pe_a, pe_b,
        output pe_c, pe_out_valid,
        input  res_valid, res_data,
        output res_ready
    );

endinterface

// File: rtl/pe_dot_sequencer_addr_gen.sv
// pe_seq_addr_gen: operand address counter.
//   clk, clr_n : clock, async active-low reset (address resets to 0)
//   load_i     : load base_i into the counter
//   step_i     : advance by stride_i (ignored while load_i is high)
//   base_i     : start address
//   stride_i   : per-step increment; sums wrap modulo 2^ADDR_WIDTH
//   addr_o     : current address (registered)
module pe_seq_addr_gen #(
    parameter int ADDR_WIDTH = pe_seq_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [ADDR_WIDTH-1:0] stride_i,
    output logic [ADDR_WIDTH-1:0] addr_o
);
    import pe_seq_pkg::*;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;

    // Same-width add drops the carry, giving the modulo wrap for free.
    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = base_i;
        end else if (step_i) begin
            addr_d = addr_q + stride_i;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/pe_dot_sequencer.sv
// pe_dot_sequencer: accepts one dot-product command, streams operand pairs
// from the A and B RAMs into the MAC PE with start/valid/last framing, waits
// for the PE result and returns it on the result handshake.
//   clk   : clock
//   clr_n : async active-low reset (aborts any command, no response)
//   bus   : pe_dot_sequencer_if.master (command, RAM, PE and result signals)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | cmd_ready high; latch command, L=0 answers 0 directly
// ST_CLEAR | pe_start pulse; load address generators with the bases
// ST_ISSUE | L back-to-back reads of both RAMs
// ST_DRAIN | wait for pe_out_valid, capture pe_c
// ST_RESP  | res_valid high, res_data held until res_ready
module pe_dot_sequencer #(
    parameter int DATA_WIDTH = pe_seq_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = pe_seq_pkg::ADDR_WIDTH,
    parameter int LEN_WIDTH  = pe_seq_pkg::LEN_WIDTH,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   clr_n,
    pe_dot_sequencer_if.master     bus
);
    import pe_seq_pkg::*;

    seq_state_e            state_q;
    logic [ADDR_WIDTH-1:0] a_base_q;
    logic [ADDR_WIDTH-1:0] b_base_q;
    logic [ADDR_WIDTH-1:0] b_stride_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic                  pe_start_q;
    logic                  mem_en_q;
    logic                  pe_valid_q;
    logic                  pe_last_q;
    logic                  res_valid_q;
    logic [ACC_WIDTH-1:0]  res_data_q;

    logic                  last_issue;
    logic                  addr_load;
    logic                  addr_step;

    assign last_issue = (state_q == ST_ISSUE) && (cnt_q == LEN_WIDTH'(1));
    assign addr_load  = (state_q == ST_CLEAR);
    assign addr_step  = (state_q == ST_ISSUE);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= ST_IDLE;
            a_base_q    <= '0;
            b_base_q    <= '0;
            b_stride_q  <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            pe_start_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            pe_valid_q  <= 1'b0;
            pe_last_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            pe_start_q <= 1'b0;
            // RAM data lands one cycle after the read, so valid/last trail the issue by one stage.
            pe_valid_q <= mem_en_q;
            pe_last_q  <= last_issue;
            case (state_q)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        a_base_q   <= bus.cmd_a_base;
                        b_base_q   <= bus.cmd_b_base;
                        b_stride_q <= bus.cmd_b_stride;
                        len_q      <= bus.cmd_len;
                        if (bus.cmd_len == '0) begin
                            res_data_q  <= '0;
                            res_valid_q <= 1'b1;
                            state_q     <= ST_RESP;
                        end else begin
                            pe_start_q <= 1'b1;
                            state_q    <= ST_CLEAR;
                        end
                    end
                end
                ST_CLEAR: begin
                    cnt_q    <= len_q;
                    mem_en_q <= 1'b1;
                    state_q  <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    cnt_q <= cnt_q - LEN_WIDTH'(1);
                    if (last_issue) begin
                        mem_en_q <= 1'b0;
                        state_q  <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (bus.pe_out_valid) begin
                        res_data_q  <= bus.pe_c;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    pe_seq_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_a (
        .clk      (clk),
        .clr_n    (clr_n),
        .load_i   (addr_load),
        .step_i   (addr_step),
        .base_i   (a_base_q),
        .stride_i (ADDR_WIDTH'(1)),
        .addr_o   (bus.mem_a_addr)
    );

    pe_seq_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_b (
        .clk      (clk),
        .clr_n    (clr_n),
        .load_i   (addr_load),
        .step_i   (addr_step),
        .base_i   (b_base_q),
        .stride_i (b_stride_q),
        .addr_o   (bus.mem_b_addr)
    );

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.mem_a_en  = mem_en_q;
    assign bus.mem_b_en  = mem_en_q;
    assign bus.pe_start  = pe_start_q;
    assign bus.pe_valid  = pe_valid_q;
    assign bus.pe_last   = pe_last_q;
    assign bus.pe_a      = bus.mem_a_rdata;
    assign bus.pe_b      = bus.mem_b_rdata;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;

endmodule

// File: tb/tb_pe_dot_sequencer.sv
// tb_pe_dot_sequencer: drives directed and random dot-product commands into
// pe_dot_sequencer with behavioural operand RAMs and a behavioural MAC PE
// (result 3 cycles after the last operand), and checks framing, addresses,
// timing and results against a plain-arithmetic dot-product model.
module tb_pe_dot_sequencer;
    import pe_seq_pkg::*;

    localparam int AW    = ADDR_WIDTH;
    localparam int DW    = DATA_WIDTH;
    localparam int AC    = ACC_WIDTH;
    localparam int LW    = LEN_WIDTH;
    localparam int DEPTH = 1 << AW;

    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    pe_dot_sequencer_if bus ();

    pe_dot_sequencer dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    logic [DW-1:0] ram_a [DEPTH];
    logic [DW-1:0] ram_b [DEPTH];

    always @(posedge clk) begin
        if (bus.mem_a_en) bus.mem_a_rdata <= ram_a[bus.mem_a_addr];
        if (bus.mem_b_en) bus.mem_b_rdata <= ram_b[bus.mem_b_addr];
    end

    // Behavioural PE: clears on start, accumulates on valid, reports the sum
    // three cycles after the last operand.
    logic [AC-1:0] pe_acc;
    logic [2:0]    pe_done_sr;
    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pe_acc     <= '0;
            pe_done_sr <= '0;
            bus.pe_c   <= '0;
        end else begin
            if (bus.pe_start)      pe_acc <= '0;
            else if (bus.pe_valid) pe_acc <= pe_acc + AC'(bus.pe_a) * AC'(bus.pe_b);
            pe_done_sr <= {pe_done_sr[1:0], bus.pe_valid & bus.pe_last};
            if (pe_done_sr[1]) bus.pe_c <= pe_acc;
        end
    end
    assign bus.pe_out_valid = pe_done_sr[2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: event logs indexed by cycle number.
    int          q_start [$];
    int          q_en    [$];
    int          q_valid [$];
    int          q_last  [$];
    int          q_res   [$];
    logic [AW-1:0] q_aa  [$];
    logic [AW-1:0] q_ba  [$];
    int          n_orphan_last = 0;
    int          n_en_split    = 0;
    always @(negedge clk) begin
        if (bus.pe_start) q_start.push_back(cyc);
        if (bus.mem_a_en) begin
            q_en.push_back(cyc);
            q_aa.push_back(bus.mem_a_addr);
            q_ba.push_back(bus.mem_b_addr);
        end
        if (bus.mem_a_en != bus.mem_b_en) n_en_split++;
        if (bus.pe_valid) q_valid.push_back(cyc);
        if (bus.pe_last) begin
            q_last.push_back(cyc);
            if (!bus.pe_valid) n_orphan_last++;
        end
        if (bus.res_valid) q_res.push_back(cyc);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] dot_model(input int a, input int b, input int s, input int len);
        logic [63:0] sum = '0;
        for (int i = 0; i < len; i++)
            sum += 64'(ram_a[(a + i) % DEPTH]) * 64'(ram_b[(b + i * s) % DEPTH]);
        return sum;
    endfunction

    int c0;
    int s_start, s_en, s_valid, s_last, s_res;

    task automatic issue_cmd(input int a, input int b, input int s, input int len);
        @(negedge clk);
        s_start = q_start.size(); s_en = q_en.size(); s_valid = q_valid.size();
        s_last  = q_last.size();  s_res = q_res.size();
        bus.cmd_valid    = 1'b1;
        bus.cmd_a_base   = AW'(a);
        bus.cmd_b_base   = AW'(b);
        bus.cmd_b_stride = AW'(s);
        bus.cmd_len      = LW'(len);
        for (int k = 0; k < 50 && !bus.cmd_ready; k++) @(negedge clk);
        check_val("cmd_ready", bus.cmd_ready, 1);
        c0 = cyc;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic finish_cmd(input int a, input int b, input int s, input int len,
                              input int hold, output logic [63:0] res);
        logic [63:0] exp;
        logic [63:0] first;
        int unstable = 0;
        int n;
        exp = dot_model(a, b, s, len);
        for (int k = 0; k < len + 40 && !bus.res_valid; k++) @(negedge clk);
        check_val("res_valid_seen", bus.res_valid, 1);
        check_val("res_latency", 64'(cyc - c0), (len == 0) ? 64'd1 : 64'(len + 6));
        check_val("cmd_ready_in_resp", bus.cmd_ready, 0);
        first = bus.res_data;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (bus.res_data !== first || !bus.res_valid || bus.cmd_ready) unstable++;
        end
        if (hold > 0) check_val("resp_hold_stable", 64'(unstable), 0);
        res = bus.res_data;
        check_val("res_data", res, exp);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check_val("res_valid_drop", bus.res_valid, 0);
        check_val("idle_cycle", 64'(cyc - c0), 64'(((len == 0) ? 2 : len + 7) + hold));
        check_val("res_cycles", 64'(q_res.size() - s_res), 64'(hold + 1));

        n = q_start.size() - s_start;
        check_val("start_count", 64'(n), (len > 0) ? 64'd1 : 64'd0);
        if (n > 0) check_val("start_cycle", 64'(q_start[s_start] - c0), 1);
        n = q_en.size() - s_en;
        check_val("en_count", 64'(n), 64'(len));
        for (int i = 0; i < len && i < n; i++) begin
            check_val("en_cycle", 64'(q_en[s_en + i] - c0), 64'(2 + i));
            check_val("a_addr", 64'(q_aa[s_en + i]), 64'((a + i) % DEPTH));
            check_val("b_addr", 64'(q_ba[s_en + i]), 64'((b + i * s) % DEPTH));
        end
        n = q_valid.size() - s_valid;
        check_val("valid_count", 64'(n), 64'(len));
        for (int i = 0; i < len && i < n; i++)
            check_val("valid_cycle", 64'(q_valid[s_valid + i] - c0), 64'(3 + i));
        n = q_last.size() - s_last;
        check_val("last_count", 64'(n), (len > 0) ? 64'd1 : 64'd0);
        if (n > 0) check_val("last_cycle", 64'(q_last[s_last] - c0), 64'(len + 2));
    endtask

    task automatic run_cmd(input int a, input int b, input int s, input int len,
                           input int hold, output logic [63:0] res);
        issue_cmd(a, b, s, len);
        finish_cmd(a, b, s, len, hold, res);
    endtask

    logic [63:0] r;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_a_base = '0; bus.cmd_b_base = '0;
        bus.cmd_b_stride = '0; bus.cmd_len = '0; bus.res_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ram_a[i] = $urandom;
            ram_b[i] = $urandom;
        end
        repeat (3) @(negedge clk);
        check_val("rst_cmd_ready", bus.cmd_ready, 1);
        check_val("rst_ctrl", {bus.pe_start, bus.pe_valid, bus.pe_last,
                               bus.mem_a_en, bus.mem_b_en, bus.res_valid}, 0);
        check_val("rst_addr", {bus.mem_a_addr, bus.mem_b_addr}, 0);
        check_val("rst_res_data", bus.res_data, 0);
        clr_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            ram_a[i]       = DW'(i + 1);
            ram_b[100 + i] = DW'(i + 5);
        end
        run_cmd(0, 100, 1, 4, 0, r);
        check_val("tp_l4_70", r, 64'd70);

        run_cmd(500, 1020, 2, 3, 0, r);

        run_cmd(7, 9, 1, 0, 0, r);
        check_val("tp_l0_zero", r, 64'd0);

        ram_a[50] = 32'hFFFF_FFFF;
        ram_b[60] = 32'hFFFF_FFFF;
        run_cmd(50, 60, 5, 1, 0, r);
        check_val("tp_l1_max", r, 64'hFFFF_FFFE_0000_0001);

        run_cmd(200, 300, 7, 5, 5, r);
        run_cmd(0, 100, 1, 2, 0, r);
        check_val("tp_no_carry_17", r, 64'd17);

        issue_cmd(10, 20, 3, 8);
        while (cyc < c0 + 3) @(negedge clk);
        check_val("pre_rst_valid", bus.pe_valid, 1);
        #2 clr_n = 1'b0;
        #1;
        check_val("abort_ctrl", {bus.pe_start, bus.pe_valid, bus.pe_last,
                                 bus.mem_a_en, bus.mem_b_en, bus.res_valid}, 0);
        check_val("abort_addr", {bus.mem_a_addr, bus.mem_b_addr}, 0);
        check_val("abort_cmd_ready", bus.cmd_ready, 1);
        repeat (3) @(negedge clk);
        clr_n = 1'b1;
        repeat (20) @(negedge clk);
        check_val("abort_no_resp", 64'(q_res.size() - s_res), 0);
        ram_a[900] = 3; ram_a[901] = 4;
        ram_b[910] = 5; ram_b[911] = 6;
        run_cmd(900, 910, 1, 2, 0, r);
        check_val("tp_after_abort_39", r, 64'd39);

        for (int t = 0; t < 12; t++) begin
            run_cmd(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)),
                    int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 20)),
                    int'($urandom_range(0, 3)), r);
        end

        check_val("last_without_valid", 64'(n_orphan_last), 0);
        check_val("en_a_b_split", 64'(n_en_split), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
